// File: rtl/id_fetch_arbiter_pkg.sv
// Shared types for the ID-stage fetch-entry arbiter: the fetch entry payload,
// the arbitration FSM states and the slot source encoding.
package id_fetch_arbiter_pkg;

  typedef struct packed {
    logic [63:0] address;
    logic [31:0] instruction;
    logic        ex_valid;
  } fetch_entry_t;

  typedef enum logic {ARB, LOCKED} arb_state_e;

  typedef enum logic {SRC_FE, SRC_INJ} id_arb_src_e;

endpackage

// File: rtl/id_arb_slot.sv
// One-entry registered output slot toward the ID stage; loads on grant,
// drains on ID acceptance and is dropped on flush.
module id_arb_slot
  import id_fetch_arbiter_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         load_i,
  input  fetch_entry_t load_entry_i,
  input  logic         load_src_i,
  input  logic         pop_i,
  output fetch_entry_t entry_o,
  output logic         valid_o,
  output logic         src_o
);

  fetch_entry_t entry_p1;
  logic         vld_p1;
  logic         src_p1;

  // Stage p1: registered slot; flush wins over both load and pop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1   <= 1'b0;
      entry_p1 <= '0;
      src_p1   <= 1'b0;
    end else if (flush_i) begin
      vld_p1 <= 1'b0;
    end else if (load_i) begin
      vld_p1   <= 1'b1;
      entry_p1 <= load_entry_i;
      src_p1   <= load_src_i;
    end else if (pop_i) begin
      vld_p1 <= 1'b0;
    end
  end

  assign entry_o = entry_p1;
  assign valid_o = vld_p1;
  assign src_o   = src_p1;

endmodule

// File: rtl/id_fetch_arbiter.sv
// Arbitrates the frontend queue and the injection port onto the ID fetch entry.
// Define ID_FETCH_ARB_PERF_EN to add grant/starvation performance counters.
module id_fetch_arbiter
  import id_fetch_arbiter_pkg::*;
#(
  parameter int unsigned MaxInjectBurst = 4,
  parameter int unsigned CntW           = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  fetch_entry_t fe_entry_i,
  input  logic         fe_valid_i,
  output logic         fe_ready_o,
  input  fetch_entry_t inj_entry_i,
  input  logic         inj_valid_i,
  output logic         inj_ready_o,
  input  logic         inj_lock_i,
  output fetch_entry_t id_entry_o,
  output logic         id_valid_o,
  input  logic         id_ready_i,
  output logic         id_src_o
`ifdef ID_FETCH_ARB_PERF_EN
  ,
  output logic [31:0]  perf_fe_grants_o,
  output logic [31:0]  perf_inj_grants_o,
  output logic [31:0]  perf_starve_o
`endif
);

  localparam logic [CntW-1:0] BurstMax = CntW'(MaxInjectBurst);

  arb_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            can_grant;
  logic            grant_fe, grant_inj;
  fetch_entry_t    grant_entry;
  id_arb_src_e     grant_src;

  assign can_grant = (!id_valid_o || id_ready_i) && !flush_i && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = inj_lock_i ? LOCKED : ARB;
    end else begin
      unique case (state_q)
        ARB:    if (inj_lock_i) state_d = LOCKED;
        LOCKED: if (!inj_lock_i && !(id_valid_o && (id_src_o == SRC_INJ))) state_d = ARB;
        default: state_d = ARB;
      endcase
    end
  end

  // Burst counter only advances while the frontend is actually contending.
  always_comb begin
    grant_fe  = 1'b0;
    grant_inj = 1'b0;
    cnt_d     = cnt_q;
    if (flush_i) begin
      cnt_d = '0;
    end else begin
      unique case (state_q)
        ARB: begin
          if (can_grant) begin
            if (inj_valid_i && (cnt_q < BurstMax)) begin
              grant_inj = 1'b1;
              cnt_d     = fe_valid_i ? cnt_q + CntW'(1) : '0;
            end else if (fe_valid_i && !inj_lock_i) begin
              grant_fe = 1'b1;
              cnt_d    = '0;
            end else if (inj_valid_i) begin
              grant_inj = 1'b1;
              cnt_d     = fe_valid_i ? cnt_q : '0;
            end
          end
          if (inj_lock_i) cnt_d = '0;
        end
        LOCKED: begin
          grant_inj = can_grant && inj_valid_i;
          cnt_d     = '0;
        end
        default: cnt_d = '0;
      endcase
    end
  end

  assign fe_ready_o  = grant_fe;
  assign inj_ready_o = grant_inj;
  assign grant_entry = grant_inj ? inj_entry_i : fe_entry_i;
  assign grant_src   = grant_inj ? SRC_INJ : SRC_FE;

  id_arb_slot i_slot (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .load_i       (grant_fe || grant_inj),
    .load_entry_i (grant_entry),
    .load_src_i   (grant_src),
    .pop_i        (id_ready_i),
    .entry_o      (id_entry_o),
    .valid_o      (id_valid_o),
    .src_o        (id_src_o)
  );

`ifdef ID_FETCH_ARB_PERF_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_fe_grants_o  <= '0;
      perf_inj_grants_o <= '0;
      perf_starve_o     <= '0;
    end else begin
      if (grant_fe)                perf_fe_grants_o  <= perf_fe_grants_o + 32'd1;
      if (grant_inj)               perf_inj_grants_o <= perf_inj_grants_o + 32'd1;
      if (fe_valid_i && !grant_fe) perf_starve_o     <= perf_starve_o + 32'd1;
    end
  end
`endif

endmodule
